adder_sweep_checker: RTL and testbench
======================================

Name: adder_sweep_checker

Overview:
- Response-side companion to the 3-bit stimulus counter that drives the concatenated full adder.
- Consumes each applied operand vector {c0,a1,a0} together with the adder's observed {c1,s}.
- Recomputes the expected result, checks that vectors arrive in strict counting order, and accumulates error counts.
- Declares pass/fail after NUM_SWEEPS complete 8-vector sweeps. It sits beside the adder in the test harness, at the receiving end of the counter-to-adder path.

Parameters:
- ERR_W, 4: width of each error counter; counters saturate at 2^ERR_W-1.
- NUM_SWEEPS, 1: number of full 8-vector sweeps (000..111) required before DONE. Legal range 1..255.

Ports:
- clk, input, 1: system clock; all state updates on posedge.
- reset, input, 1: synchronous, active-low reset.
- clr, input, 1: synchronous clear; returns to IDLE and zeroes all counters/flags.
- valid, input, 1: the operand and result inputs are sampled this cycle.
- a0, input, 1: applied operand bit 0.
- a1, input, 1: applied operand bit 1.
- c0, input, 1: applied carry-in.
- s, input, 1: observed sum from the adder.
- c1, input, 1: observed carry-out from the adder.
- busy, output, 1: high in RUN.
- done, output, 1: high in DONE.
- pass, output, 1: high in DONE when res_err_cnt==0 and seq_err_cnt==0.
- res_err_cnt, output, ERR_W: count of vectors whose {c1,s} mismatched.
- seq_err_cnt, output, ERR_W: count of out-of-order vectors.
- first_err_vec, output, 3: {c0,a1,a0} of the first result mismatch (optional feature).
- first_err_obs, output, 2: observed {c1,s} of the first result mismatch (optional feature).

Behaviour:
- Reset (reset==0 at posedge), all outputs 0:
  - State=IDLE; busy=0, done=0, pass=0.
  - res_err_cnt=0, seq_err_cnt=0; first_err_vec=0, first_err_obs=0.
  - Internal exp_vec=0, sweep_cnt=0.
- Priority: reset > clr > valid.
  - clr in any state behaves as reset except that it is gated by reset.
  - clr and valid asserted in the same cycle: the vector is dropped.
- Expected result: exp = a0 + a1 + c0 (2-bit, {c1,s}). The vector is a result error when {c1,s} != exp.
- State machine:
  - IDLE:
    - Ignores valid unless {c0,a1,a0}==3'b000.
    - A valid 000 vector is checked and consumed, exp_vec becomes 1, and the state moves to RUN.
    - Any other valid vector is discarded without counting; this is the sweep-alignment wait.
  - RUN:
    - On each valid, check the result.
    - Check sequence: {c0,a1,a0} != exp_vec means seq_err_cnt+1.
    - exp_vec then resyncs to {c0,a1,a0}+1 (mod 8), so a single skip counts once.
    - When the consumed vector is 111, sweep_cnt+1. If sweep_cnt reaches NUM_SWEEPS, go to DONE.
    - valid low: no state change; gaps of any length are legal.
  - DONE:
    - Holds all counters and pass; ignores valid.
    - Exits only via clr or reset.
- Latency:
  - Counters and first_err update at the posedge sampling the vector; values are visible the next cycle.
  - done/pass assert the cycle after the final 111 vector is accepted.
- Wrap-around: exp_vec wraps 7 to 0, which is legal and not a sequence error.
- Saturation: each counter holds at all-ones and never wraps. Result and sequence errors on the same vector increment both counters.
- pass is combinationally derived from registered state: done && both counters zero.

Optional Feature:
- Macro: FIRST_ERR_CAPTURE_EN.
- Defined:
  - On the first result error since reset/clr, latch first_err_vec={c0,a1,a0} and first_err_obs={c1,s}.
  - Later errors do not overwrite the latched values.
  - Values are cleared only by reset or clr.
- Undefined: first_err_vec and first_err_obs are tied to 0 and no capture registers are built.

Test Plan:
- Ideal adder, valid every cycle, vectors 000..111, NUM_SWEEPS=1 -> done=1 and pass=1 the cycle after 111; both counters 0; busy=0.
- Sweep with c1 forced 0 -> res_err_cnt=4 (vectors 011,101,110,111); pass=0. With FIRST_ERR_CAPTURE_EN: first_err_vec=3'b011, first_err_obs=2'b00.
- Vectors 000,001,011,100..111 (010 skipped) -> seq_err_cnt=1, res_err_cnt=0, done=1, pass=0.
- Start at 101 with reset released -> ignored until the next 000; then a full sweep gives done=1, pass=1.
- NUM_SWEEPS=2: clr asserted mid-second-sweep at vector 100 -> IDLE next cycle with all counters 0; a fresh 2 sweeps are then needed for done.
- 20 consecutive result errors with ERR_W=4 over 3 sweeps (NUM_SWEEPS=3) -> res_err_cnt saturates at 15, does not wrap; reset low for one cycle -> all outputs 0.

Source files
------------

// File: rtl/adder_sweep_checker.sv
// adder_sweep_checker: checks 3-bit adder sweep results and ordering; FIRST_ERR_CAPTURE_EN enables first-error capture
module adder_sweep_checker #(
  parameter int ERR_W = 4,
  parameter int NUM_SWEEPS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             valid,
  input  logic             a0,
  input  logic             a1,
  input  logic             c0,
  input  logic             s,
  input  logic             c1,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] res_err_cnt,
  output logic [ERR_W-1:0] seq_err_cnt,
  output logic [2:0]       first_err_vec,
  output logic [1:0]       first_err_obs
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [2:0] exp_vec, vec;
  logic [1:0] obs, exp_obs;
  logic [7:0] sweep_cnt, sweep_nxt;
  logic accept, res_err, seq_err, last;
  assign vec = {c0, a1, a0};
  assign obs = {c1, s};
  assign exp_obs = {1'b0, a0} + {1'b0, a1} + {1'b0, c0};
  assign res_err = obs != exp_obs;
  assign accept = valid && (state == RUN || (state == IDLE && vec == 3'd0));
  assign seq_err = state == RUN && vec != exp_vec;
  assign last = state == RUN && vec == 3'd7;
  assign sweep_nxt = sweep_cnt + 8'(last);
  assign busy = state == RUN;
  assign done = state == DONE;
  assign pass = done && res_err_cnt == '0 && seq_err_cnt == '0;
  always_ff @(posedge clk)
    if (!reset || clr) begin
      state <= IDLE;
      exp_vec <= '0;
      sweep_cnt <= '0;
      res_err_cnt <= '0;
      seq_err_cnt <= '0;
    end else if (accept) begin
      state <= last && sweep_nxt == 8'(NUM_SWEEPS) ? DONE : RUN;
      exp_vec <= vec + 3'd1;
      sweep_cnt <= sweep_nxt;
      res_err_cnt <= res_err_cnt + ERR_W'(res_err && res_err_cnt != '1);
      seq_err_cnt <= seq_err_cnt + ERR_W'(seq_err && seq_err_cnt != '1);
    end
`ifdef FIRST_ERR_CAPTURE_EN
  always_ff @(posedge clk)
    if (!reset || clr) begin
      first_err_vec <= '0;
      first_err_obs <= '0;
    end else if (accept && res_err && res_err_cnt == '0) begin
      first_err_vec <= vec;
      first_err_obs <= obs;
    end
`else
  assign first_err_vec = '0;
  assign first_err_obs = '0;
`endif
endmodule

// File: tb/tb_adder_sweep_checker.sv
// tb_adder_sweep_checker: directed and random sweeps checked against a behavioural model
module tb_adder_sweep_checker;
  localparam int EW = 4, NS = 3, SAT = 15;
  logic clk = 0, reset = 0, clr = 0, valid = 0, a0 = 0, a1 = 0, c0 = 0, s = 0, c1 = 0;
  logic busy, done, pass;
  logic [EW-1:0] res_err_cnt, seq_err_cnt;
  logic [2:0] first_err_vec;
  logic [1:0] first_err_obs;
  int n_checks = 0, n_fail = 0;
  bit chk_en = 0;
  int m_phase = 0, m_next = 0, m_sweeps = 0, m_res = 0, m_seq = 0;
  logic [2:0] m_fvec = 0;
  logic [1:0] m_fobs = 0;

  adder_sweep_checker #(.ERR_W(EW), .NUM_SWEEPS(NS)) dut (
    .clk(clk), .reset(reset), .clr(clr), .valid(valid),
    .a0(a0), .a1(a1), .c0(c0), .s(s), .c1(c1),
    .busy(busy), .done(done), .pass(pass),
    .res_err_cnt(res_err_cnt), .seq_err_cnt(seq_err_cnt),
    .first_err_vec(first_err_vec), .first_err_obs(first_err_obs)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] add3(logic [2:0] v);
    int sum;
    sum = int'(v[0]) + int'(v[1]) + int'(v[2]);
    return sum[1:0];
  endfunction

  function automatic int sat(int x);
    return x > SAT ? SAT : x;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(bit r, bit cl, bit v, logic [2:0] vec, logic [1:0] obs);
    if (!r || cl) begin
      m_phase = 0; m_next = 0; m_sweeps = 0; m_res = 0; m_seq = 0; m_fvec = 0; m_fobs = 0;
    end else if (v && (m_phase == 1 || (m_phase == 0 && vec == 0))) begin
      if (obs != add3(vec)) begin
        if (m_res == 0) begin m_fvec = vec; m_fobs = obs; end
        m_res++;
      end
      if (m_phase == 1 && int'(vec) != m_next) m_seq++;
      m_next = (int'(vec) + 1) % 8;
      if (m_phase == 0) m_phase = 1;
      else if (vec == 7) begin
        m_sweeps++;
        if (m_sweeps == NS) m_phase = 2;
      end
    end
  endtask

  always @(negedge clk)
    if (chk_en) begin
      check("busy", busy, m_phase == 1);
      check("done", done, m_phase == 2);
      check("pass", pass, m_phase == 2 && m_res == 0 && m_seq == 0);
      check("res_err_cnt", res_err_cnt, sat(m_res));
      check("seq_err_cnt", seq_err_cnt, sat(m_seq));
`ifdef FIRST_ERR_CAPTURE_EN
      check("first_err_vec", first_err_vec, m_fvec);
      check("first_err_obs", first_err_obs, m_fobs);
`else
      check("first_err_vec", first_err_vec, 0);
      check("first_err_obs", first_err_obs, 0);
`endif
    end

  task automatic cyc(bit r, bit cl, bit v, logic [2:0] vec, logic [1:0] obs);
    reset = r; clr = cl; valid = v; {c0, a1, a0} = vec; {c1, s} = obs;
    @(posedge clk);
    model(r, cl, v, vec, obs);
    @(negedge clk);
  endtask

  task automatic good(logic [2:0] vec);
    cyc(1, 0, 1, vec, add3(vec));
  endtask

  // mode 0: ideal adder, 1: carry stuck at 0, 2: sum inverted
  task automatic sweeps(int n, int mode);
    logic [2:0] vec;
    logic [1:0] obs;
    for (int i = 0; i < n * 8; i++) begin
      vec = 3'(i);
      obs = add3(vec);
      if (mode == 1) obs[1] = 1'b0;
      if (mode == 2) obs[0] = ~obs[0];
      cyc(1, 0, 1, vec, obs);
    end
  endtask

  initial begin
    logic [2:0] stim, vec;
    logic [1:0] obs;
    bit r, cl, v;
    chk_en = 1;
    cyc(0, 0, 0, 0, 0);
    check("lit_reset_busy", busy, 0);
    check("lit_reset_res", res_err_cnt, 0);
    sweeps(NS, 0);
    check("lit_ideal_done", done, 1);
    check("lit_ideal_pass", pass, 1);
    check("lit_ideal_busy", busy, 0);
    cyc(0, 0, 0, 0, 0);
    sweeps(NS, 1);
    check("lit_c1stuck_res", res_err_cnt, 4 * NS);
    check("lit_c1stuck_pass", pass, 0);
    check("lit_c1stuck_done", done, 1);
`ifdef FIRST_ERR_CAPTURE_EN
    check("lit_first_vec", first_err_vec, 3);
    check("lit_first_obs", first_err_obs, 0);
`endif
    cyc(0, 0, 0, 0, 0);
    good(0); good(1); good(3); good(4); good(5); good(6); good(7);
    sweeps(NS - 1, 0);
    check("lit_skip_seq", seq_err_cnt, 1);
    check("lit_skip_res", res_err_cnt, 0);
    check("lit_skip_done", done, 1);
    check("lit_skip_pass", pass, 0);
    cyc(0, 0, 0, 0, 0);
    good(5); good(6); good(7);
    check("lit_align_busy", busy, 0);
    sweeps(NS, 0);
    check("lit_align_pass", pass, 1);
    cyc(0, 0, 0, 0, 0);
    sweeps(1, 0);
    good(0); good(1); good(2); good(3);
    cyc(1, 1, 1, 4, add3(4));
    check("lit_clr_busy", busy, 0);
    check("lit_clr_done", done, 0);
    sweeps(NS - 1, 0);
    check("lit_clr_notdone", done, 0);
    sweeps(1, 0);
    check("lit_clr_done_after", done, 1);
    cyc(0, 0, 0, 0, 0);
    sweeps(NS, 2);
    check("lit_sat_res", res_err_cnt, 15);
    cyc(0, 0, 0, 0, 0);
    check("lit_rst_res", res_err_cnt, 0);
    check("lit_rst_done", done, 0);
    check("lit_rst_pass", pass, 0);
    stim = 0;
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 499) != 0;
      cl = $urandom_range(0, 149) == 0;
      v = $urandom_range(0, 3) != 0;
      vec = $urandom_range(0, 9) < 8 ? stim : 3'($urandom_range(0, 7));
      obs = $urandom_range(0, 9) == 0 ? 2'($urandom_range(0, 3)) : add3(vec);
      cyc(r, cl, v, vec, obs);
      if (v) stim = vec + 3'd1;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
